// File: rtl/dma_request_arbiter_pkg.sv
// dma_pkg: shared constants, channel-index width helper and arbiter state type.
package dma_pkg;
  localparam logic [3:0] REQ_ADDR_DEFAULT = 4'b1001;
  function automatic int ch_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/dma_request_arbiter_if.sv
// dma_request_arbiter_if: CPU I/O port, hardware request and grant signals of the DMA request arbiter.
interface dma_request_arbiter_if
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = ch_w(NUM_CH)
) ();
  logic              IOR;
  logic              IOW;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataBus;
  logic [DATA_W-1:0] ReadData;
  logic              Master_Clear;
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] Mask;
  logic [NUM_CH-1:0] TC;
  logic              Rotate;
  logic              Service_Done;
  logic [NUM_CH-1:0] Pending;
  logic              Grant_Valid;
  logic [CH_W-1:0]   Grant_Ch;
  modport master (
    output IOR, IOW, Address, DataBus, Master_Clear, DREQ, Mask, TC, Rotate, Service_Done,
    input  ReadData, Pending, Grant_Valid, Grant_Ch
  );
  modport slave (
    input  IOR, IOW, Address, DataBus, Master_Clear, DREQ, Mask, TC, Rotate, Service_Done,
    output ReadData, Pending, Grant_Valid, Grant_Ch
  );
endinterface

// File: rtl/dma_request_arbiter_priority.sv
// dma_priority_arbiter: picks the first pending channel, searching from ch0 or from last_served+1.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   last_served,
  input  logic              rotate,
  output logic [CH_W-1:0]   winner
);
  int start;
  always_comb begin
    start = rotate ? (int'(last_served) + 1) % NUM_CH : 0;
    winner = '0;
    // walk backwards so the candidate closest to start is assigned last and wins
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[(start + i) % NUM_CH]) winner = CH_W'((start + i) % NUM_CH);
  end
endmodule

// File: rtl/dma_request_arbiter.sv
// dma_request_arbiter: software/hardware DMA request register with fixed or rotating
// priority arbitration and a grant held until Service_Done.
module dma_request_arbiter
  import dma_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              ADDR_W      = 4,
  parameter int              DATA_W      = 8,
  parameter logic [ADDR_W-1:0] REQ_ADDR  = ADDR_W'(REQ_ADDR_DEFAULT),
  parameter int              SYNC_STAGES = 2,
  localparam int             CH_W        = ch_w(NUM_CH)
) (
  input logic                 CLK,
  input logic                 Reset,
  dma_request_arbiter_if.slave bus
);
  logic [NUM_CH-1:0] sw_req, sw_next, dreq_sync;
  logic [CH_W-1:0]   grant_ch, grant_next, last_served, last_next, winner, wr_ch;
  arb_state_t        state, state_next;
  logic              wr, rd;
  assign wr    = !bus.IOW && bus.IOR && bus.Address == REQ_ADDR;
  assign rd    = !bus.IOR && bus.IOW && bus.Address == REQ_ADDR;
  assign wr_ch = bus.DataBus[CH_W-1:0];
  assign bus.ReadData    = rd ? DATA_W'(sw_req) : '0;
  assign bus.Pending     = (sw_req | dreq_sync) & ~bus.Mask;
  assign bus.Grant_Valid = state == BUSY;
  assign bus.Grant_Ch    = grant_ch;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge CLK or posedge Reset)
      if (Reset) sr <= '0;
      else if (bus.Master_Clear) sr <= '0;
      else sr <= {sr[SYNC_STAGES-2:0], bus.DREQ[c]};
    assign dreq_sync[c] = sr[SYNC_STAGES-1];
  end
  // terminal count is applied after the write so it wins on the same channel
  always_comb begin
    sw_next = sw_req;
    if (wr && int'(wr_ch) < NUM_CH) sw_next[wr_ch] = bus.DataBus[CH_W];
    sw_next = sw_next & ~bus.TC;
  end
  dma_priority_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending     (bus.Pending),
    .last_served (last_served),
    .rotate      (bus.Rotate),
    .winner      (winner)
  );
  always_comb begin
    state_next = state;
    grant_next = grant_ch;
    last_next  = last_served;
    if (state == IDLE && bus.Pending != '0) begin
      state_next = BUSY;
      grant_next = winner;
    end else if (state == BUSY && bus.Service_Done) begin
      state_next = IDLE;
      last_next  = bus.Rotate ? grant_ch : last_served;
    end
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset || bus.Master_Clear) begin
      sw_req      <= '0;
      state       <= IDLE;
      grant_ch    <= '0;
      last_served <= CH_W'(NUM_CH - 1);
    end else begin
      sw_req      <= sw_next;
      state       <= state_next;
      grant_ch    <= grant_next;
      last_served <= last_next;
    end
endmodule
